// File: rtl/dice_pkg.sv
// Shared types and helpers for the N-player dice arbiter.
package dice_pkg;

  localparam int DICE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    HELD    = 2'd2
  } ch_state_t;

  // Ceiling log2; constant-evaluable so it can size ports and counters.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dice_channel.sv
// One player channel: start edge detect, IDLE/ROLLING/HELD FSM,
// roll-length counter and wrapping face counter.
module dice_channel
  import dice_pkg::*;
#(
  parameter int FACES       = 6,
  parameter int ROLL_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              acc,
  output logic [DICE_W-1:0] dice,
  output logic              rolling,
  output logic              held
);

  localparam int CNT_W = clog2(ROLL_CYCLES + 1);

  ch_state_t         st, st_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DICE_W-1:0] face_nx;
  logic              start_q;
  logic              rise;

  assign rise    = start & ~start_q;
  // A rise only counts when it actually launches a roll.
  assign acc     = rise & (st != ROLLING);
  assign rolling = (st == ROLLING);
  assign held    = (st == HELD);

  // Next state: launch on edge, otherwise step face and count down the window.
  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    face_nx = dice;
    case (st)
      IDLE, HELD: begin
        if (rise) begin
          st_nx  = ROLLING;
          cnt_nx = CNT_W'(ROLL_CYCLES);
        end
      end
      ROLLING: begin
        face_nx = (dice == DICE_W'(FACES)) ? DICE_W'(1) : dice + DICE_W'(1);
        cnt_nx  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) st_nx = HELD;
      end
      default: st_nx = IDLE;
    endcase
  end

  // State, counters and the edge-detect register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      dice    <= DICE_W'(1);
      start_q <= 1'b0;
    end else begin
      st      <= st_nx;
      cnt     <= cnt_nx;
      dice    <= face_nx;
      start_q <= start;
    end
  end

endmodule

// File: rtl/dice_roll_arbiter.sv
// N-player dice roller: per-channel dice plus finish arbitration and
// a max-face / lowest-index winner compare stage.
module dice_roll_arbiter
  import dice_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int FACES       = 6,
  parameter int ROLL_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          start,
  input  logic                     finish,
  output logic [DICE_W*N_CH-1:0]   dice,
  output logic [N_CH-1:0]          rolling,
  output logic [N_CH-1:0]          held,
  output logic                     result_valid,
  output logic [clog2(N_CH)-1:0]   winner,
  output logic                     tie,
  output logic [DICE_W-1:0]        max_face,
  output logic                     finish_rej
);

  localparam int WIN_W  = clog2(N_CH);
  localparam int STAGES = 1;

  logic [N_CH-1:0][DICE_W-1:0] dice_a;
  logic [N_CH-1:0]             acc;
  logic                        fin_q, fin_rise, fin_acc;
  logic [STAGES:0]             vld_pipe;
  logic [DICE_W-1:0]           cmp_max;
  logic [WIN_W-1:0]            cmp_win;
  logic [3:0]                  cmp_cnt;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      dice_channel #(
        .FACES       (FACES),
        .ROLL_CYCLES (ROLL_CYCLES)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .start   (start[g]),
        .acc     (acc[g]),
        .dice    (dice_a[g]),
        .rolling (rolling[g]),
        .held    (held[g])
      );
    end
  endgenerate

  assign dice     = dice_a;
  assign fin_rise = finish & ~fin_q;
  // Launching any roll in the same cycle makes the held values stale, so start wins.
  assign fin_acc  = fin_rise & (&held) & ~(|acc);
  assign vld_pipe[0] = fin_acc;

  // Compare: strict > keeps the lowest index on equal faces; second pass counts ties.
  always_comb begin
    cmp_max = '0;
    cmp_win = '0;
    cmp_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (dice_a[i] > cmp_max) begin
        cmp_max = dice_a[i];
        cmp_win = WIN_W'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (dice_a[i] == cmp_max) cmp_cnt = cmp_cnt + 4'd1;
    end
  end

  // Finish edge detect, accept pipeline and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fin_q                <= 1'b0;
      vld_pipe[STAGES:1]   <= '0;
      result_valid         <= 1'b0;
      winner               <= '0;
      tie                  <= 1'b0;
      max_face             <= '0;
      finish_rej           <= 1'b0;
    end else begin
      fin_q              <= finish;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      finish_rej         <= fin_rise & ~fin_acc;
      // Dice are still frozen one cycle after acceptance, so compare them now.
      if (vld_pipe[STAGES]) begin
        winner   <= cmp_win;
        tie      <= (cmp_cnt > 4'd1);
        max_face <= cmp_max;
      end
      if (|acc)                  result_valid <= 1'b0;
      else if (vld_pipe[STAGES]) result_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Scoreboard bench: driver runs a timeline model of the game and queues the
// expected outputs per cycle; a monitor pops and compares after each posedge.
module tb_dice_roll_arbiter;
  localparam int N = 2;
  localparam int F = 6;
  localparam int R = 10;

  typedef struct packed {
    logic [4*N-1:0] dice;
    logic [N-1:0]   rolling;
    logic [N-1:0]   held;
    logic           rv;
    logic           win;
    logic           tie;
    logic [3:0]     mx;
    logic           rej;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   start = '0;
  logic           finish = 1'b0;
  logic [4*N-1:0] dice;
  logic [N-1:0]   rolling, held;
  logic           result_valid, winner, tie, finish_rej;
  logic [3:0]     max_face;

  int nvec = 0;
  int nerr = 0;
  exp_t q[$];

  dice_roll_arbiter #(.N_CH(N), .FACES(F), .ROLL_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .dice(dice),
    .rolling(rolling), .held(held), .result_valid(result_valid),
    .winner(winner), .tie(tie), .max_face(max_face), .finish_rej(finish_rej)
  );

  always #5 clk = ~clk;

  // Model: each channel is a roll that began at posedge m_t0 from face m_v0.
  int   p = 0;
  bit   m_go[N];
  int   m_t0[N];
  int   m_v0[N];
  bit   m_sprev[N];
  bit   m_fprev, m_rv, m_tie, m_rej, m_pend;
  int   m_win, m_max, pd_win, pd_max;
  bit   pd_tie;

  function automatic int face_at(int i, int t);
    int k;
    if (!m_go[i]) return 1;
    k = t - m_t0[i];
    if (k > R) k = R;
    return ((m_v0[i] - 1 + k) % F) + 1;
  endfunction

  function automatic bit rolling_at(int i, int t);
    return m_go[i] && (t - m_t0[i] < R);
  endfunction

  function automatic bit held_at(int i, int t);
    return m_go[i] && (t - m_t0[i] >= R);
  endfunction

  task automatic model_step(input logic [N-1:0] s, input logic f, input logic r);
    bit allheld, any, fe, acc;
    int cnt;
    exp_t e;
    p++;
    if (r) begin
      for (int i = 0; i < N; i++) begin m_go[i] = 0; m_sprev[i] = 0; end
      m_fprev = 0; m_rv = 0; m_win = 0; m_tie = 0; m_max = 0; m_rej = 0; m_pend = 0;
    end else begin
      allheld = 1;
      for (int i = 0; i < N; i++) if (!held_at(i, p - 1)) allheld = 0;
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (s[i] && !m_sprev[i] && !rolling_at(i, p - 1)) begin
          m_v0[i] = face_at(i, p - 1);
          m_t0[i] = p;
          m_go[i] = 1;
          any = 1;
        end
      end
      fe = f && !m_fprev;
      if (m_pend) begin m_win = pd_win; m_tie = pd_tie; m_max = pd_max; end
      if (any) m_rv = 0;
      else if (m_pend) m_rv = 1;
      acc = fe && allheld && !any;
      m_rej = fe && !acc;
      m_pend = acc;
      if (acc) begin
        pd_max = 0; pd_win = 0; cnt = 0;
        for (int i = 0; i < N; i++) if (face_at(i, p) > pd_max) begin pd_max = face_at(i, p); pd_win = i; end
        for (int i = 0; i < N; i++) if (face_at(i, p) == pd_max) cnt++;
        pd_tie = (cnt >= 2);
      end
      for (int i = 0; i < N; i++) m_sprev[i] = s[i];
      m_fprev = f;
    end
    for (int i = 0; i < N; i++) begin
      e.dice[4*i +: 4] = 4'(face_at(i, p));
      e.rolling[i]     = rolling_at(i, p);
      e.held[i]        = held_at(i, p);
    end
    e.rv = m_rv; e.win = m_win[0]; e.tie = m_tie; e.mx = 4'(m_max); e.rej = m_rej;
    q.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] s, input logic f, input logic r);
    @(negedge clk);
    start = s; finish = f; rst = r;
    model_step(s, f, r);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: one queued expectation per posedge, compared just after the edge.
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = '{dice, rolling, held, result_valid, winner, tie, max_face, finish_rej};
        nvec++;
        if (g !== e) begin
          nerr++;
          $display("FAIL cycle %0d: got %h expected %h (dice,roll,held,rv,win,tie,max,rej)", nvec, g, e);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] s;
    repeat (3) drive('0, 0, 1);

    // Channel 0 held high for 1000 cycles, channel 1 pulsed, then finish.
    for (int c = 0; c < 1000; c++) drive({c == 3, 1'b1}, c == 30, 0);
    chk("dice0_first", dice[3:0], 5);
    chk("dice1_first", dice[7:4], 5);
    chk("rv_first", result_valid, 1);
    chk("win_first", winner, 0);
    chk("tie_first", tie, 1);
    chk("max_first", max_face, 5);

    // Re-roll channel 0.
    drive(2'b00, 0, 0);
    drive(2'b01, 0, 0);
    drive(2'b01, 0, 0);
    chk("rv_drop", result_valid, 0);
    chk("roll0_reroll", rolling[0], 1);
    repeat (15) drive(2'b00, 0, 0);
    chk("dice0_reroll", dice[3:0], 3);
    drive(2'b00, 1, 0);
    repeat (3) drive(2'b00, 0, 0);
    chk("win_second", winner, 1);
    chk("tie_second", tie, 0);
    chk("max_second", max_face, 5);
    chk("rv_second", result_valid, 1);

    // Only channel 0 rolled: finish refused.
    repeat (2) drive('0, 0, 1);
    repeat (12) drive(2'b01, 0, 0);
    drive(2'b00, 0, 0);
    drive(2'b00, 1, 0);
    drive(2'b00, 0, 0);
    chk("rej_pulse", finish_rej, 1);
    drive(2'b00, 0, 0);
    chk("rej_clear", finish_rej, 0);
    chk("rv_refused", result_valid, 0);

    // Start re-pulsed mid-roll, then reset mid-roll.
    drive(2'b01, 0, 0);
    repeat (3) drive(2'b00, 0, 0);
    drive(2'b01, 0, 0);
    repeat (12) drive(2'b00, 0, 0);
    drive(2'b01, 0, 0);
    repeat (5) drive(2'b00, 0, 0);
    drive(2'b00, 0, 1);
    drive(2'b00, 0, 0);
    chk("rst_dice0", dice[3:0], 1);
    chk("rst_rolling", rolling, 0);
    chk("rst_held", held, 0);

    // Start and finish on the same edge with both held.
    drive(2'b11, 0, 0);
    repeat (12) drive(2'b00, 0, 0);
    drive(2'b10, 1, 0);
    drive(2'b00, 0, 0);
    chk("sim_rej", finish_rej, 1);
    chk("sim_roll1", rolling[1], 1);
    chk("sim_rv", result_valid, 0);

    // Random traffic.
    s = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 19) == 0) s[i] = ~s[i];
      drive(s, $urandom_range(0, 9) == 0, $urandom_range(0, 399) == 0);
    end

    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
